line_follow_ctrl: RTL

- Parametrised successor to the bot's line-following FSM. Sensor count, ADC width, thresholds, settle/timeout durations and motor duty levels are all parameters.
- New behaviour:
  - explicit valid/ready handshake with the node-planning block for turn commands;
  - node-detect hold-off counter;
  - lost-line recovery with a bounded timeout that ends in fault;
  - per-speed-mode duty selection.
- Sits between the ADC sampler and the motor PWM driver.

---
 rtl/line_follow_pkg.sv | 32 +++
 rtl/line_follow_ctrl_if.sv | 9 +
 rtl/line_sensor_classifier.sv | 52 +++++
 rtl/line_follow_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared types for the line-following controller: FSM states, turn command codes and
// sensor classification.
package line_follow_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSettle,
        StFollow,
        StSteerL,
        StSteerR,
        StNode,
        StDecide,
        StTurnL,
        StTurnR,
        StLost,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsCenter,
        ClsLeft,
        ClsRight,
        ClsNone,
        ClsNode
    } cls_e;

    localparam logic [2:0] DirLeft     = 3'd0;
    localparam logic [2:0] DirRight    = 3'd1;
    localparam logic [2:0] DirStraight = 3'd2;
    localparam logic [2:0] DirStop     = 3'd3;

endpackage

// File: rtl/line_follow_ctrl_if.sv
// Turn-command handshake between the node planner (master) and the controller (slave).
interface line_follow_ctrl_if;
    logic [2:0] dir_cmd;
    logic       dir_valid;
    logic       dir_ready;

    modport master (output dir_cmd, output dir_valid, input dir_ready);
    modport slave  (input dir_cmd, input dir_valid, output dir_ready);
endinterface

// File: rtl/line_sensor_classifier.sv
// Registers the packed reflectance samples and classifies them (1-cycle latency).
module line_sensor_classifier
    import line_follow_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 3,
    parameter int unsigned ADC_W       = 12,
    parameter int unsigned LINE_TH     = 250,
    parameter int unsigned NODE_TH     = 950
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SENSORS*ADC_W-1:0] adc_data,
    output cls_e                         cls
);

    localparam int unsigned Mid = NUM_SENSORS / 2;
    localparam logic [ADC_W-1:0] LineTh = ADC_W'(LINE_TH);
    localparam logic [ADC_W-1:0] NodeTh = ADC_W'(NODE_TH);

    logic [NUM_SENSORS*ADC_W-1:0] samples_q;
    logic node_seen, left_any, right_any, mid_bit;

    always_ff @(posedge clock) begin
        if (reset) samples_q <= '0;
        else       samples_q <= adc_data;
    end

    always_comb begin
        node_seen = 1'b0;
        left_any  = 1'b0;
        right_any = 1'b0;
        mid_bit   = 1'b0;
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
            if (samples_q[i*ADC_W +: ADC_W] > NodeTh) node_seen = 1'b1;
            if (samples_q[i*ADC_W +: ADC_W] > LineTh) begin
                if (i < Mid)      left_any  = 1'b1;
                else if (i > Mid) right_any = 1'b1;
                else              mid_bit   = 1'b1;
            end
        end
    end

    // Line on both sides of centre is treated as centred.
    always_comb begin
        if (node_seen)                                cls = ClsNode;
        else if (left_any && !right_any)              cls = ClsLeft;
        else if (right_any && !left_any)              cls = ClsRight;
        else if (!mid_bit && !left_any && !right_any) cls = ClsNone;
        else                                          cls = ClsCenter;
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following controller: follows the line, stops at nodes for a planner command,
// recovers a lost line within a bounded spin and drives registered motor duties.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 3,
    parameter int unsigned ADC_W       = 12,
    parameter int unsigned LINE_TH     = 250,
    parameter int unsigned NODE_TH     = 950,
    parameter int unsigned SETTLE_CYC  = 2000000,
    parameter int unsigned HOLDOFF_CYC = 100000,
    parameter int unsigned LOST_CYC    = 10000000,
    parameter int unsigned DUTY_W      = 4,
    parameter int unsigned DUTY_FAST   = 7,
    parameter int unsigned DUTY_SLOW   = 5,
    parameter int unsigned DUTY_TURN   = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         slow_mode,
    input  logic [NUM_SENSORS*ADC_W-1:0] adc_data,
    line_follow_ctrl_if.slave            dir_bus,
    output logic [DUTY_W-1:0]            mla,
    output logic [DUTY_W-1:0]            mlb,
    output logic [DUTY_W-1:0]            mra,
    output logic [DUTY_W-1:0]            mrb,
    output logic                         node_pulse,
    output logic [7:0]                   node_count,
    output logic                         fault,
    output logic                         halted
);

    localparam int unsigned CntMax = (LOST_CYC > SETTLE_CYC) ? LOST_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned HoldW  = $clog2(HOLDOFF_CYC + 1);
    localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0]   LostLast   = CntW'(LOST_CYC - 1);
    localparam logic [CntW-1:0]   CntSat     = CntW'(CntMax);
    localparam logic [HoldW-1:0]  HoldMax    = HoldW'(HOLDOFF_CYC);
    localparam logic [DUTY_W-1:0] DutyFast   = DUTY_W'(DUTY_FAST);
    localparam logic [DUTY_W-1:0] DutySlow   = DUTY_W'(DUTY_SLOW);
    localparam logic [DUTY_W-1:0] DutyTurn   = DUTY_W'(DUTY_TURN);

    cls_e cls;

    line_sensor_classifier #(
        .NUM_SENSORS (NUM_SENSORS),
        .ADC_W       (ADC_W),
        .LINE_TH     (LINE_TH),
        .NODE_TH     (NODE_TH)
    ) u_classifier (
        .clock    (clock),
        .reset    (reset),
        .adc_data (adc_data),
        .cls      (cls)
    );

    state_e state_q, state_d, target_q, target_d, settle_tgt;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [HoldW-1:0]  holdoff_q, holdoff_d;
    logic [7:0]        node_count_q;
    logic              fault_q, fault_d, enable_q, dir_ready_q;
    logic              settle_req, node_ok, node_entry;
    logic [DUTY_W-1:0] mla_d, mlb_d, mra_d, mrb_d;
    logic [DUTY_W-1:0] mla_q, mlb_q, mra_q, mrb_q;
    logic              node_pulse_q, halted_q;

    assign node_ok    = (cls == ClsNode) && (holdoff_q == HoldMax);
    assign node_entry = (state_d == StNode) && (state_q != StNode);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        fault_d    = fault_q;
        settle_req = 1'b0;
        settle_tgt = StFollow;
        unique case (state_q)
            StIdle:   if (enable) settle_req = 1'b1;
            StSettle: if (cnt_q == SettleLast) state_d = target_q;
            StFollow: begin
                if (node_ok) state_d = StNode;
                else if (cls == ClsLeft) begin
                    settle_req = 1'b1;
                    settle_tgt = StSteerL;
                end else if (cls == ClsRight) begin
                    settle_req = 1'b1;
                    settle_tgt = StSteerR;
                end else if (cls == ClsNone) state_d = StLost;
            end
            StSteerL, StSteerR: begin
                if (node_ok)                 state_d    = StNode;
                else if (cls == ClsCenter)   settle_req = 1'b1;
            end
            StNode: if (cls == ClsCenter || cls == ClsNone) state_d = StDecide;
            StDecide: begin
                if (dir_bus.dir_valid && dir_ready_q) begin
                    case (dir_bus.dir_cmd)
                        DirLeft:  state_d = StTurnL;
                        DirRight: state_d = StTurnR;
                        DirStop:  state_d = StHalt;
                        default:  state_d = StFollow;
                    endcase
                end
            end
            StTurnL, StTurnR: if (cnt_q >= SettleLast && cls == ClsCenter) settle_req = 1'b1;
            StLost: begin
                if (cls != ClsNone) settle_req = 1'b1;
                else if (cnt_q == LostLast) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end
            end
            StHalt: begin
                if (enable && !enable_q) begin
                    state_d = StIdle;
                    fault_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pause with motors off before a new motion, unless it is the motion already running.
        if (settle_req) begin
            if (settle_tgt == state_q) state_d = settle_tgt;
            else begin
                state_d  = StSettle;
                target_d = settle_tgt;
            end
        end

        if (!enable && state_q != StIdle && state_q != StHalt) state_d = StHalt;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
        holdoff_d = holdoff_q;
        if (node_entry)              holdoff_d = '0;
        else if (holdoff_q != HoldMax) holdoff_d = holdoff_q + HoldW'(1);
    end

    // Duties follow the next state so a transition and its drive appear together.
    always_comb begin
        mla_d = '0;
        mlb_d = '0;
        mra_d = '0;
        mrb_d = '0;
        unique case (state_d)
            StFollow: begin
                mla_d = slow_mode ? DutySlow : DutyFast;
                mra_d = slow_mode ? DutySlow : DutyFast;
            end
            StSteerL, StTurnL, StLost: begin
                mlb_d = DutyTurn;
                mra_d = DutyTurn;
            end
            StSteerR, StTurnR: begin
                mla_d = DutyTurn;
                mrb_d = DutyTurn;
            end
            StNode: begin
                mla_d = DutyTurn;
                mra_d = DutyTurn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            target_q     <= StIdle;
            cnt_q        <= '0;
            holdoff_q    <= HoldMax;
            node_count_q <= '0;
            fault_q      <= 1'b0;
            enable_q     <= 1'b0;
            dir_ready_q  <= 1'b0;
            node_pulse_q <= 1'b0;
            halted_q     <= 1'b0;
            mla_q        <= '0;
            mlb_q        <= '0;
            mra_q        <= '0;
            mrb_q        <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            holdoff_q    <= holdoff_d;
            node_count_q <= node_entry ? node_count_q + 8'd1 : node_count_q;
            fault_q      <= fault_d;
            enable_q     <= enable;
            dir_ready_q  <= (state_d == StDecide);
            node_pulse_q <= node_entry;
            halted_q     <= (state_d == StHalt);
            mla_q        <= mla_d;
            mlb_q        <= mlb_d;
            mra_q        <= mra_d;
            mrb_q        <= mrb_d;
        end
    end

    assign dir_bus.dir_ready = dir_ready_q;
    assign mla               = mla_q;
    assign mlb               = mlb_q;
    assign mra               = mra_q;
    assign mrb               = mrb_q;
    assign node_pulse        = node_pulse_q;
    assign node_count        = node_count_q;
    assign fault             = fault_q;
    assign halted            = halted_q;

endmodule
